pipeline_hazard_ctrl: RTL

//   Sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings and pipeline constants for the hazard controller.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_X0    = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detect: ID source register matches a load destination in EX.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure compare.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_read_mem,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
        // x0 is hardwired zero, so a load targeting it never creates a dependency
        load_use = ex_read_mem && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register enable/flush sequencer: load-use stalls, EX redirects, dmem waits.
// Latency: controls are combinational from registered state + current inputs.
// Backpressure: an outstanding dmem access freezes every stage until mem_ack.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_read_mem,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WC_W-1:0] WAIT_LIMIT   = WC_W'(MEM_TIMEOUT);

    hz_state_t        state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic load_use;
    logic mem_stall;
    logic wait_cycle;
    logic event_inc;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_read_mem (ex_read_mem),
        .load_use    (load_use)
    );

    assign mem_stall = mem_req && !mem_ack;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        wait_cycle    = 1'b0;
        event_inc     = 1'b0;

        case (state_q)
            ST_RUN, ST_FLUSH: begin
                if (mem_stall) begin
                    // flush_cnt is kept so a pending IF/ID flush resumes after the wait
                    {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
                    wait_cycle = 1'b1;
                    wait_cnt_d = WC_W'(1);
                    state_d    = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    event_inc   = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end else begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end
                end else if (state_q == ST_FLUSH) begin
                    if_id_flush = 1'b1;
                    if (flush_cnt_q <= FC_W'(1)) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FC_W'(1);
                    end
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    wait_cnt_d = '0;
                    state_d    = (flush_cnt_q != '0) ? ST_FLUSH : ST_RUN;
                end else begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
                    wait_cycle = 1'b1;
                    if (wait_cnt_q != WAIT_LIMIT) begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (wait_cycle && (wait_cnt_d == WAIT_LIMIT)) begin
            mem_timeout_d = 1'b1;
        end

        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        flush_events_d = flush_events_q;
        if (event_inc && (flush_events_q != '1)) begin
            flush_events_d = flush_events_q + CNT_W'(1);
        end

        if (rst) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            flush_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule
